dct_block_arbiter: RTL and testbench

DCT_BLOCK_ARBITER -- requirements
Module: dct_block_arbiter

---
 rtl/dct_block_arbiter.sv | 154 +++++++++++++++
 tb/tb_dct_block_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_arbiter.sv
// dct_block_arbiter
// Purpose: shares one forward-DCT row input between up to four component
// streams (0=Y, 1=Cb, 2=Cr). A block is eight rows. The arbiter grants one
// requester for a whole block, forwards each accepted row one cycle later,
// and flags rows whose sob/eob markers disagree with the internal row count.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   req_valid/ready[N]    per-requester row handshake
//   req_data[N][8][W]     one 8-sample row per requester
//   req_sob/eob/sof[N]    block start, block end and frame start markers
//   out_valid             forwarded row strobe (no backpressure downstream)
//   out_data[8][W]        forwarded row
//   out_sob/eob/sof       forwarded markers
//   out_comp              index of the requester that owns the forwarded row
//   err                   one-cycle pulse: block framing violation
//
// Handshake: a row transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready never depends on req_valid, so a
// requester may hold valid and wait. Only the granted requester sees ready,
// and only in LOCKED; ready is low throughout reset.
module dct_block_arbiter #(
    parameter int W = 8,
    parameter int N = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             req_valid,
    input  logic [N-1:0][7:0][W-1:0] req_data,
    input  logic [N-1:0]             req_sob,
    input  logic [N-1:0]             req_eob,
    input  logic [N-1:0]             req_sof,
    output logic [N-1:0]             req_ready,
    output logic                     out_valid,
    output logic [7:0][W-1:0]        out_data,
    output logic                     out_sob,
    output logic                     out_eob,
    output logic                     out_sof,
    output logic [1:0]               out_comp,
    output logic                     err
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic       state;
    logic [1:0] grant;
    logic [1:0] last;
    logic [2:0] row_cnt;

    // Row presented by the granted requester.
    logic            sel_valid;
    logic [7:0][W-1:0] sel_data;
    logic            sel_sob;
    logic            sel_eob;
    logic            sel_sof;
    logic            accept;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_sob   = 1'b0;
        sel_eob   = 1'b0;
        sel_sof   = 1'b0;
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == 2'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i];
                sel_sob   = req_sob[i];
                sel_eob   = req_eob[i];
                sel_sof   = req_sof[i];
            end
            req_ready[i] = rst_n && (state == ST_LOCKED) && (grant == 2'(i));
        end
    end

    assign accept = (state == ST_LOCKED) && sel_valid;

    // Round-robin search starting one past the last winner. Only requesters
    // presenting a start-of-block row are eligible, so a stream that lost
    // its place (e.g. after reset) cannot be granted mid-block.
    logic       found;
    logic [1:0] winner;
    int         idx;

    always_comb begin
        found  = 1'b0;
        winner = last;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            for (int i = 0; i < N; i++) begin
                if (!found && (i == idx) && req_valid[i] && req_sob[i]) begin
                    found  = 1'b1;
                    winner = 2'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= 2'd0;
            last      <= 2'(N - 1);
            row_cnt   <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_comp  <= 2'd0;
            err       <= 1'b0;
        end else begin
            // Markers are strobes; data and comp hold when nothing is accepted.
            out_valid <= accept;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            err       <= 1'b0;
            if (accept) begin
                out_data <= sel_data;
                out_sob  <= sel_sob;
                out_eob  <= sel_eob;
                out_sof  <= sel_sof;
                out_comp <= grant;
                err      <= (sel_sob != (row_cnt == 3'd0)) ||
                            (sel_eob != (row_cnt == 3'd7));
            end

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant   <= winner;
                        last    <= winner;
                        row_cnt <= 3'd0;
                        state   <= ST_LOCKED;
                    end
                end
                default: begin
                    // Block end is decided by the row count alone; a stray
                    // eob only raises err.
                    if (accept) begin
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_block_arbiter.sv
// tb_dct_block_arbiter
// Purpose: directed bench for dct_block_arbiter (W=8, N=3). A per-cycle
// vector table covers a clean Cb block and a Y block with a gap and a
// misplaced eob; hand sequences cover three-way contention, long gaps with
// a pending competitor, and reset in the middle of a block.
module tb_dct_block_arbiter;

    localparam int W = 8;
    localparam int N = 3;

    logic                     clk;
    logic                     rst_n;
    logic [N-1:0]             req_valid;
    logic [N-1:0][7:0][W-1:0] req_data;
    logic [N-1:0]             req_sob;
    logic [N-1:0]             req_eob;
    logic [N-1:0]             req_sof;
    logic [N-1:0]             req_ready;
    logic                     out_valid;
    logic [7:0][W-1:0]        out_data;
    logic                     out_sob;
    logic                     out_eob;
    logic                     out_sof;
    logic [1:0]               out_comp;
    logic                     err;

    dct_block_arbiter #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_sob   (req_sob),
        .req_eob   (req_eob),
        .req_sof   (req_sof),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sob   (out_sob),
        .out_eob   (out_eob),
        .out_sof   (out_sof),
        .out_comp  (out_comp),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] exp_q[$];
    logic [1:0]  comp_q[$];
    logic [63:0] exp_data;

    typedef struct {
        logic [2:0] vld;
        logic [2:0] sob;
        logic [2:0] eob;
        logic [2:0] sof;
        int         seed;
        logic [2:0] rdy;
        logic       ov;
        logic [1:0] comp;
        logic       osob;
        logic       oeob;
        logic       osof;
        logic       oerr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] mk_row(input int s);
        logic [7:0][7:0] r;
        for (int k = 0; k < 8; k++) r[k] = 8'(s * 7 + k * 13 + 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_sob   = '0;
        req_eob   = '0;
        req_sof   = '0;
        req_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for n edges with the current inputs and checks that every
    // output reads zero.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int c = 0; c < n; c++) begin
            #1;
            chk("rst_ready", 64'(req_ready), 64'd0);
            tick();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_out_flags", {61'd0, out_sob, out_eob, out_sof}, 64'd0);
            chk("rst_out_comp", 64'(out_comp), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
        end
        rst_n    = 1'b1;
        exp_data = '0;
    endtask

    // ---------------- driver: table ----------------
    task automatic addv(input logic [2:0] vld, input logic [2:0] sob, input logic [2:0] eob,
                        input logic [2:0] sof, input int seed, input logic [2:0] rdy,
                        input logic ov, input logic [1:0] comp, input logic osob,
                        input logic oeob, input logic osof, input logic oerr);
        vec_t v;
        v.vld = vld; v.sob = sob; v.eob = eob; v.sof = sof; v.seed = seed;
        v.rdy = rdy; v.ov = ov; v.comp = comp; v.osob = osob; v.oeob = oeob;
        v.osof = osof; v.oerr = oerr;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        req_valid = v.vld;
        req_sob   = v.sob;
        req_eob   = v.eob;
        req_sof   = v.sof;
        for (int i = 0; i < N; i++) req_data[i] = mk_row(v.seed + i * 100);
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(v.rdy));
        tick();
        if (v.ov) exp_data = mk_row(v.seed + int'(v.comp) * 100);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(v.ov));
        chk({tag, "_out_comp"}, 64'(out_comp), 64'(v.comp));
        chk({tag, "_out_data"}, out_data, exp_data);
        chk({tag, "_flags"}, {61'd0, out_sob, out_eob, out_sof}, {61'd0, v.osob, v.oeob, v.osof});
        chk({tag, "_err"}, 64'(err), 64'(v.oerr));
    endtask

    // ---------------- test ----------------
    initial begin
        int r[N];
        logic [2:0] acc;
        logic [1:0] order[4];
        logic y_pat[14];
        int yr;
        int blk;
        int ph;

        rst_n = 1'b0;
        clear_inputs();
        exp_data = '0;

        // Clean Cb block: one arbitration cycle, then 8 back-to-back rows.
        addv(3'b010, 3'b010, 3'b000, 3'b010, 16, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            addv(3'b010, (k == 0) ? 3'b010 : 3'b000, (k == 7) ? 3'b010 : 3'b000,
                 (k == 0) ? 3'b010 : 3'b000, 16 + k, 3'b010,
                 1'b1, 2'd1, k == 0, k == 7, k == 0, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 3'b000, 0, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Y block: gap after row 2, stray eob on row 4 (err), block still runs 8 rows.
        addv(3'b001, 3'b001, 3'b000, 3'b000, 32, 3'b000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b001, 3'b000, 3'b000, 32, 3'b001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b000, 3'b000, 3'b000, 33, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b000, 3'b000, 3'b000, 34, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 3'b000, 99, 3'b001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b000, 3'b000, 3'b000, 35, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b000, 3'b001, 3'b000, 36, 3'b001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        addv(3'b001, 3'b000, 3'b000, 3'b000, 37, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b000, 3'b000, 3'b000, 38, 3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        addv(3'b001, 3'b000, 3'b001, 3'b000, 39, 3'b001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        addv(3'b000, 3'b000, 3'b000, 3'b000, 0, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset(2);
        for (int n = 0; n < vecs.size(); n++) apply_vec(vecs[n], n);

        // Contention: all three hold sob rows; expect Y, Cb, Cr, Y with one
        // idle cycle before each block.
        clear_inputs();
        do_reset(1);
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back(mk_row(int'(order[b]) * 64 + k));
                comp_q.push_back(order[b]);
            end
        for (int i = 0; i < N; i++) r[i] = 0;
        for (int c = 0; c < 36; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = 1'b1;
                req_sob[i]   = (r[i] == 0);
                req_eob[i]   = (r[i] == 7);
                req_sof[i]   = (r[i] == 0);
                req_data[i]  = mk_row(i * 64 + r[i]);
            end
            #1;
            acc = req_ready & req_valid;
            tick();
            for (int i = 0; i < N; i++) if (acc[i]) r[i] = (r[i] + 1) % 8;
            blk = c / 9;
            ph  = c % 9;
            chk($sformatf("cont_valid_c%0d", c), 64'(out_valid), 64'(ph != 0));
            if (out_valid && ph != 0 && exp_q.size() > 0) begin
                chk($sformatf("cont_comp_c%0d", c), 64'(out_comp), 64'(comp_q.pop_front()));
                chk($sformatf("cont_data_c%0d", c), out_data, exp_q.pop_front());
                chk($sformatf("cont_sob_eob_c%0d", c), {62'd0, out_sob, out_eob},
                    {62'd0, ph == 1, ph == 8});
                chk($sformatf("cont_err_c%0d", c), 64'(err), 64'd0);
            end
        end
        chk("cont_scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Gaps: Y pauses 3 cycles after rows 2 and 5 while Cr waits with sob.
        clear_inputs();
        do_reset(1);
        y_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        req_valid = 3'b101;
        req_sob   = 3'b101;
        req_data[2] = mk_row(200);
        req_data[0] = mk_row(150);
        #1;
        chk("gap_arb_ready", 64'(req_ready), 64'd0);
        tick();
        yr = 0;
        for (int c = 0; c < 14; c++) begin
            req_valid[0] = y_pat[c];
            req_sob[0]   = y_pat[c] && (yr == 0);
            req_eob[0]   = y_pat[c] && (yr == 7);
            req_data[0]  = mk_row(150 + yr);
            #1;
            chk($sformatf("gap_ready_c%0d", c), 64'(req_ready), 64'b001);
            acc = req_ready & req_valid;
            tick();
            chk($sformatf("gap_valid_c%0d", c), 64'(out_valid), 64'(y_pat[c]));
            if (acc[0]) begin
                chk($sformatf("gap_comp_c%0d", c), 64'(out_comp), 64'd0);
                chk($sformatf("gap_data_c%0d", c), out_data, mk_row(150 + yr));
                yr++;
            end
        end
        chk("gap_y_rows", 64'(yr), 64'd8);
        req_valid[0] = 1'b0;
        req_sob[0]   = 1'b0;
        req_eob[0]   = 1'b0;
        #1;
        chk("gap_rearb_ready", 64'(req_ready), 64'd0);
        tick();
        #1;
        chk("gap_cr_ready", 64'(req_ready), 64'b100);
        tick();
        chk("gap_cr_valid", 64'(out_valid), 64'd1);
        chk("gap_cr_comp", 64'(out_comp), 64'd2);
        chk("gap_cr_data", out_data, mk_row(200));

        // Reset after row 3 of a Cb block; the stale block must not resume.
        clear_inputs();
        do_reset(1);
        for (int c = 0; c < 5; c++) begin
            req_valid = 3'b010;
            req_sob   = (c <= 1) ? 3'b010 : 3'b000;
            req_data[1] = mk_row(80 + ((c == 0) ? 0 : c - 1));
            tick();
        end
        chk("mid_row3_valid", 64'(out_valid), 64'd1);
        chk("mid_row3_data", out_data, mk_row(83));
        req_sob     = 3'b000;
        req_data[1] = mk_row(84);
        do_reset(2);
        #1;
        chk("mid_stale_ready", 64'(req_ready), 64'd0);
        tick();
        chk("mid_stale_valid", 64'(out_valid), 64'd0);
        req_valid   = 3'b011;
        req_sob     = 3'b011;
        req_data[0] = mk_row(120);
        req_data[1] = mk_row(90);
        #1;
        chk("mid_arb_ready", 64'(req_ready), 64'd0);
        tick();
        #1;
        chk("mid_y_ready", 64'(req_ready), 64'b001);
        tick();
        chk("mid_y_valid", 64'(out_valid), 64'd1);
        chk("mid_y_comp", 64'(out_comp), 64'd0);
        chk("mid_y_data", out_data, mk_row(120));

        clear_inputs();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
